// File: rtl/regfile_sb.sv
// regfile_sb -- multi-ported register file with per-register pending-write
// scoreboard.
//
// Ports:
//   clk, reset_n         clock; asynchronous active-low reset
//   ra / rd / rrdy       READ_PORTS read addresses, data, operand-ready flags
//   rsv_valid/addr/ready reservation of a register by a new producer
//   wvalid / wa / wd     WRITE_PORTS writeback ports (highest index wins)
//   flush                clears every pending counter
//   busy                 per-register "pending count nonzero" (registered)
//   err                  sticky flag: writeback with no pending reservation

// One read lane: address decode, optional same-cycle bypass and the
// operand-ready check against the scoreboard.
module regfile_sb_rport #(
    parameter int NREGS       = 32,
    parameter int DATA_W      = 64,
    parameter int WRITE_PORTS = 2,
    parameter int PEND_W      = 2,
    parameter int BYPASS      = 1,
    parameter int ZERO_REG    = 1,
    localparam int AW         = $clog2(NREGS)
) (
    input  logic [AW-1:0]                        ra,
    input  logic [NREGS-1:0][DATA_W-1:0]         mem,
    input  logic [NREGS-1:0][PEND_W-1:0]         cnt,
    input  logic [WRITE_PORTS-1:0]               wvalid,
    input  logic [WRITE_PORTS-1:0][AW-1:0]       wa,
    input  logic [WRITE_PORTS-1:0][DATA_W-1:0]   wd,
    input  logic                                 rsv_acc,
    input  logic [AW-1:0]                        rsv_addr,
    output logic [DATA_W-1:0]                    rd,
    output logic                                 rrdy
);
    logic              hit;
    logic [DATA_W-1:0] bdat;

    always_comb begin
        hit  = 1'b0;
        bdat = '0;
        // Ascending scan so the highest-numbered matching port wins.
        for (int j = 0; j < WRITE_PORTS; j++) begin
            if (wvalid[j] && wa[j] == ra) begin
                hit  = 1'b1;
                bdat = wd[j];
            end
        end
        rd = mem[ra];
        if (BYPASS != 0 && hit) rd = bdat;
        if (ZERO_REG != 0 && ra == '0) rd = '0;
        // Last outstanding write landing now makes the operand ready, unless a
        // new producer claims the register in the same cycle.
        rrdy = (cnt[ra] == '0) ||
               (BYPASS != 0 && cnt[ra] == PEND_W'(1) && hit &&
                !(rsv_acc && rsv_addr == ra));
    end
endmodule

module regfile_sb #(
    parameter int NREGS       = 32,
    parameter int DATA_W      = 64,
    parameter int READ_PORTS  = 4,
    parameter int WRITE_PORTS = 2,
    parameter int PEND_W      = 2,
    parameter int BYPASS      = 1,
    parameter int ZERO_REG    = 1,
    localparam int AW         = $clog2(NREGS)
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [READ_PORTS-1:0][AW-1:0]        ra,
    output logic [READ_PORTS-1:0][DATA_W-1:0]    rd,
    output logic [READ_PORTS-1:0]                rrdy,
    input  logic                                 rsv_valid,
    input  logic [AW-1:0]                        rsv_addr,
    output logic                                 rsv_ready,
    input  logic [WRITE_PORTS-1:0]               wvalid,
    input  logic [WRITE_PORTS-1:0][AW-1:0]       wa,
    input  logic [WRITE_PORTS-1:0][DATA_W-1:0]   wd,
    input  logic                                 flush,
    output logic [NREGS-1:0]                     busy,
    output logic                                 err
);
    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

    logic [NREGS-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [NREGS-1:0][PEND_W-1:0] cnt_q, cnt_d;
    logic                         err_q, err_d;
    logic                         rsv_acc;
    logic                         rsv_whit;

    // A write to the target frees a slot this cycle, so a saturated counter
    // can still take a new reservation.
    always_comb begin
        rsv_whit = 1'b0;
        for (int j = 0; j < WRITE_PORTS; j++)
            if (wvalid[j] && wa[j] == rsv_addr) rsv_whit = 1'b1;
        rsv_ready = (cnt_q[rsv_addr] != CNT_MAX) || rsv_whit;
    end

    assign rsv_acc = rsv_valid && rsv_ready;

    always_comb begin
        int nw;
        int inc;
        int nxt;
        mem_d = mem_q;
        cnt_d = cnt_q;
        err_d = err_q;
        for (int i = 0; i < NREGS; i++) begin
            nw = 0;
            for (int j = 0; j < WRITE_PORTS; j++) begin
                if (wvalid[j] && wa[j] == AW'(i)) begin
                    nw = nw + 1;
                    if (!(ZERO_REG != 0 && i == 0)) mem_d[i] = wd[j];
                end
            end
            // Flush drops same-cycle reservations.
            inc = (rsv_acc && !flush && rsv_addr == AW'(i)) ? 1 : 0;
            if (ZERO_REG != 0 && i == 0) begin
                cnt_d[i] = '0;
            end else begin
                nxt = int'(cnt_q[i]) + inc - nw;
                if (nxt < 0) begin
                    nxt   = 0;
                    err_d = 1'b1;
                end
                cnt_d[i] = flush ? '0 : PEND_W'(nxt);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            assign busy[gi] = |cnt_q[gi];
        end
        for (gi = 0; gi < READ_PORTS; gi++) begin : g_rport
            regfile_sb_rport #(
                .NREGS(NREGS), .DATA_W(DATA_W), .WRITE_PORTS(WRITE_PORTS),
                .PEND_W(PEND_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
            ) u_rport (
                .ra(ra[gi]), .mem(mem_q), .cnt(cnt_q),
                .wvalid(wvalid), .wa(wa), .wd(wd),
                .rsv_acc(rsv_acc), .rsv_addr(rsv_addr),
                .rd(rd[gi]), .rrdy(rrdy[gi])
            );
        end
    endgenerate

    assign err = err_q;
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
    localparam int NREGS = 32, DATA_W = 64, RP = 4, WP = 2, AW = 5;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [RP-1:0][AW-1:0]     ra;
    logic [RP-1:0][DATA_W-1:0] rd;
    logic [RP-1:0]             rrdy;
    logic                      rsv_valid;
    logic [AW-1:0]             rsv_addr;
    logic                      rsv_ready;
    logic [WP-1:0]             wvalid;
    logic [WP-1:0][AW-1:0]     wa;
    logic [WP-1:0][DATA_W-1:0] wd;
    logic                      flush;
    logic [NREGS-1:0]          busy;
    logic                      err;

    int ntests = 0;
    int nfail  = 0;

    regfile_sb dut (
        .clk(clk), .reset_n(reset_n), .ra(ra), .rd(rd), .rrdy(rrdy),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .wvalid(wvalid), .wa(wa), .wd(wd), .flush(flush),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wvalid    = '0;
        rsv_valid = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        rsv_addr = '0;
        wa = '0;
        wd = '0;
        ra[0] = 5'd5; ra[1] = 5'd3; ra[2] = 5'd7; ra[3] = 5'd0;
        #3;
        chk("rst_rd", rd, '0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_rrdy", rrdy, 4'hf);
        #5 reset_n = 1'b1;
        step();

        // r5: reserve, then write with bypass
        rsv_valid = 1'b1; rsv_addr = 5'd5;
        #1 chk("r5_rsv_ready", rsv_ready, 1);
        step(); idle();
        #1 chk("r5_busy", busy[5], 1);
        chk("r5_rrdy_pend", rrdy[0], 0);
        wvalid = 2'b01; wa[0] = 5'd5; wd[0] = 64'hDEAD;
        #1 chk("r5_bypass", rd[0], 64'hDEAD);
        chk("r5_rrdy_byp", rrdy[0], 1);
        step(); idle();
        #1 chk("r5_stored", rd[0], 64'hDEAD);
        chk("r5_busy_clr", busy[5], 0);
        chk("r5_err", err, 0);

        // r3: two reservations, both ports write same cycle
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        step(); step(); idle();
        #1 chk("r3_busy", busy[3], 1);
        wvalid = 2'b11; wa[0] = 5'd3; wa[1] = 5'd3; wd[0] = 64'h11; wd[1] = 64'h22;
        #1 chk("r3_bypass_win", rd[1], 64'h22);
        step(); idle();
        #1 chk("r3_stored", rd[1], 64'h22);
        chk("r3_busy_clr", busy[3], 0);
        chk("r3_err", err, 0);

        // r7: saturate counter at 3
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        repeat (3) step();
        #1 chk("r7_full", rsv_ready, 0);
        chk("r7_rrdy", rrdy[2], 0);
        wvalid = 2'b01; wa[0] = 5'd7; wd[0] = 64'h77;
        #1 chk("r7_ready_w", rsv_ready, 1);
        step(); wvalid = '0;
        #1 chk("r7_still3", rsv_ready, 0);
        rsv_valid = 1'b0;
        wvalid = 2'b01;
        step(); step();
        #1 chk("r7_rrdy_last", rrdy[2], 1);
        step(); idle();
        #1 chk("r7_busy_clr", busy[7], 0);
        chk("r7_err", err, 0);
        chk("r7_data", rd[2], 64'h77);

        // r0 hardwired zero
        wvalid = 2'b01; wa[0] = 5'd0; wd[0] = 64'hFF;
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        #1 chk("r0_rd_byp", rd[3], 0);
        chk("r0_rsv_ready", rsv_ready, 1);
        step(); idle();
        #1 chk("r0_rd", rd[3], 0);
        chk("r0_busy", busy, 0);
        chk("r0_err", err, 0);

        // r9: write without reservation -> sticky err
        ra[0] = 5'd9;
        wvalid = 2'b01; wa[0] = 5'd9; wd[0] = 64'h99;
        step(); idle();
        #1 chk("r9_data", rd[0], 64'h99);
        chk("r9_err", err, 1);
        chk("r9_busy", busy[9], 0);
        repeat (10) step();
        chk("r9_err_sticky", err, 1);

        // flush with same-cycle reservation
        rsv_valid = 1'b1; rsv_addr = 5'd4;
        step(); idle();
        #1 chk("fl_busy4", busy[4], 1);
        flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 5'd6;
        step(); idle();
        ra[1] = 5'd6;
        #1 chk("fl_busy", busy, 0);
        chk("fl_rrdy6", rrdy[1], 1);

        // asynchronous reset mid-cycle
        #2 reset_n = 1'b0;
        #1 chk("mr_err", err, 0);
        chk("mr_rd9", rd[0], 0);
        chk("mr_busy", busy, 0);
        chk("mr_rrdy", rrdy, 4'hf);
        ra[0] = 5'd5;
        #1 chk("mr_rd5", rd[0], 0);
        reset_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
